fc_ifm_streamer: RTL

FC_IFM_STREAMER -- requirements
Module: fc_ifm_streamer

---
 rtl/fc_pkg.sv | 7 +
 rtl/ifm_skid_reg.sv | 35 +++
 rtl/fc_ifm_streamer.sv | 91 +++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// fc_pkg: state encodings and default dimensions shared by the FC controller and IFM streamer.
package fc_pkg;
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} fc_state_e;
    localparam int FC_IFM_SIZE   = 9162;
    localparam int FC_DATA_WIDTH = 8;
    localparam int FC_ADDR_WIDTH = 14;
endpackage

// File: rtl/ifm_skid_reg.sv
// ifm_skid_reg: one-entry holding register for a read word that returns while the receiver stalls.
module ifm_skid_reg
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = FC_DATA_WIDTH
) (
    input  logic                  clk1,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  drain,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] dout
);
    logic                  full_q, full_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    always_comb begin
        full_d = load ? 1'b1 : (drain ? 1'b0 : full_q);
        data_d = load ? din : data_q;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign dout = data_q;
endmodule

// File: rtl/fc_ifm_streamer.sv
// fc_ifm_streamer: reads one feature map from source memory and presents it word by word,
// honouring a receiver stall without losing or duplicating words.
module fc_ifm_streamer
    import fc_pkg::*;
#(
    parameter int IFM_SIZE   = FC_IFM_SIZE,
    parameter int DATA_WIDTH = FC_DATA_WIDTH,
    parameter int ADDR_WIDTH = FC_ADDR_WIDTH
) (
    input  logic                  clk1,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  hold,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  valid_ifm,
    output logic [DATA_WIDTH-1:0] ifm_data,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           word_count
);
    localparam logic [31:0] LAST = 32'(IFM_SIZE);

    fc_state_e             state_q, state_d;
    logic [31:0]           rd_cnt_q, rd_cnt_d, wc_q, wc_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  pend_q, valid_q, valid_d, take, skid_full;
    logic [DATA_WIDTH-1:0] data_q, data_d, skid_data;

    ifm_skid_reg #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk1  (clk1),
        .rst_n (rst_n),
        .load  (pend_q && hold),
        .drain (take && skid_full),
        .din   (mem_rdata),
        .full  (skid_full),
        .dout  (skid_data)
    );

    always_comb begin
        // Reads stop the moment hold rises, so at most one word is ever in flight.
        mem_rd_en = (state_q == STREAM) && !hold && !skid_full && (rd_cnt_q < LAST);
        take      = !hold && (skid_full || pend_q);
        valid_d   = take;
        data_d    = take ? (skid_full ? skid_data : mem_rdata) : data_q;
        wc_d      = take ? wc_q + 32'd1 : wc_q;
        rd_cnt_d  = mem_rd_en ? rd_cnt_q + 32'd1 : rd_cnt_q;
        base_d    = base_q;
        state_d   = state_q;
        case (state_q)
            IDLE: if (start) begin
                state_d  = STREAM;
                base_d   = base_addr;
                rd_cnt_d = '0;
                wc_d     = '0;
            end
            STREAM: if (mem_rd_en && rd_cnt_q == LAST - 32'd1) state_d = DRAIN;
            DRAIN:  if (valid_q && wc_q == LAST) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rd_cnt_q <= '0;
            wc_q     <= '0;
            base_q   <= '0;
            pend_q   <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            wc_q     <= wc_d;
            base_q   <= base_d;
            pend_q   <= mem_rd_en;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    assign mem_addr   = base_q + rd_cnt_q[ADDR_WIDTH-1:0];
    assign valid_ifm  = valid_q;
    assign ifm_data   = data_q;
    assign busy       = (state_q == STREAM) || (state_q == DRAIN);
    assign done       = (state_q == DONE);
    assign word_count = wc_q;
endmodule
